clock_divider_sequencer: RTL and testbench
==========================================

// Module: clock_divider_sequencer
//
// PURPOSE
// Consumes the raw oscillator clock and gates it through a start-up stabilisation window.
// Then produces a programmable divided clock (clk_out), a one-cycle tick strobe and a
// ready flag for downstream logic.
// Sits directly after the oscillator; all slow-domain blocks key off clk_out/tick.
//
// PARAMETERS
// STABLE_CYCLES  16  consecutive enabled clock cycles required before RUN
// DIV_WIDTH      8   width of half-period divide ratio
// DEFAULT_DIV    10  half-period ratio after reset (clk_out period = 2*DEFAULT_DIV clocks)
//
// PORTS
// clock      in   1          oscillator clock; all logic on posedge
// reset      in   1          asynchronous, active-high reset
// enable     in   1          request to start (1) / stop (0) divided clock
// div_ratio  in   DIV_WIDTH  new half-period ratio; 0 is treated as 1
// div_load   in   1          1-cycle strobe: capture div_ratio as pending ratio
// clk_out    out  1          divided clock, registered, 50% duty
// tick       out  1          1-cycle pulse in the cycle clk_out rises
// ready      out  1          high only while state==RUN
// state      out  2          current FSM state (debug)
//
// BEHAVIOUR
// - Reset (async assert, sync-to-clock deassert not required): state=HOLD, clk_out=0.
//   tick=0, ready=0, counters=0, active_div=pending_div=DEFAULT_DIV, pending_valid=0.
// - HOLD: enable=1 -> STABILIZE (stab_cnt cleared). clk_out held 0.
// - STABILIZE: stab_cnt increments each cycle enable=1; enable=0 -> HOLD, stab_cnt=0.
//   At stab_cnt==STABLE_CYCLES-1 with enable=1 -> RUN next cycle.
//   ready rises on that entry cycle, exactly STABLE_CYCLES cycles after leaving HOLD.
// - RUN: half_cnt counts 0..active_div-1. At terminal count, half_cnt wraps to 0 and clk_out toggles.
//   The first rising clk_out occurs active_div cycles after entering RUN.
//   tick=1 exactly in the cycles where clk_out goes 0->1; otherwise 0.
//   Period of clk_out = 2*active_div clocks; div 1 gives clock/2.
// - Ratio change (glitch-free): div_load sets pending_div (0 mapped to 1) and pending_valid.
//   Repeated loads overwrite; last wins. Pending ratio is applied only at a terminal count
//   where clk_out goes 1->0 (full-period boundary); pending_valid then clears.
//   A div_load in the same cycle as that boundary is applied at that boundary (bypass).
//   Ratio never changes mid-period.
// - RUN with enable=0: if clk_out=0 -> HOLD next cycle. If clk_out=1 -> STOPPING.
//   Either way, ready drops next cycle.
// - STOPPING: continue counting the current high phase. At terminal count clk_out->0
//   and state->HOLD. tick is never asserted. enable=1 here is ignored until HOLD is reached.
// - Counters saturate nowhere; half_cnt is DIV_WIDTH bits, stab_cnt is $clog2(STABLE_CYCLES+1) bits.
// - reset asserted mid-operation: immediate return to reset values, incl. clk_out=0 and pending ratio dropped.
//
// STRUCTURE
// - Package clock_divider_pkg: state_t enum (HOLD=2'd0, STABILIZE=2'd1, RUN=2'd2, STOPPING=2'd3).
//   It also holds the localparam default-ratio helper function sanitize_div (0->1).
// - Sub-module half_period_counter (clock, reset, run, load_val, count_en -> terminal).
//   It is the reloadable DIV_WIDTH counter; FSM, ratio shadowing and clk_out/tick regs stay in top.
//
// TESTING
// 1. Reset, enable=1 held, DEFAULT_DIV=10 -> ready rises 16 cycles after HOLD exit.
//    First clk_out rise 10 cycles later with tick; period 20.
// 2. In STABILIZE, drop enable at cycle 7 then reassert -> back to HOLD, full 16-cycle window restarts.
// 3. RUN, div_load div_ratio=3 mid high phase -> current period completes at 20.
//    Following periods are 6 clocks, no short/long pulse.
// 4. div_ratio=0 loaded -> clk_out period 2 clocks, tick every 2 cycles.
//    Two loads (4 then 5) in one period -> 5 applied.
// 5. enable=0 while clk_out=1 -> STOPPING, clk_out falls at end of high phase, then HOLD.
//    ready low the cycle after enable drop, no tick.
// 6. reset pulse during RUN with clk_out=1 -> clk_out, tick, ready=0 immediately, state=HOLD.
//    The pending ratio is lost and active_div is back to 10.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg: shared state encoding, default sizes and ratio sanitising helper
package clock_divider_pkg;
    localparam int DIV_W       = 8;
    localparam int DEF_DIV     = 10;
    localparam int DEF_STABLE  = 16;
    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2,
        STOPPING  = 2'd3
    } state_t;
    // A half-period of zero clocks is meaningless; treat it as the fastest ratio.
    function automatic logic [DIV_W-1:0] sanitize_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction
endpackage

// File: rtl/half_period_counter.sv
// half_period_counter: reloadable half-period counter flagging the last count of each phase
//   clock    in  oscillator clock
//   reset    in  async active-high reset
//   run      in  0 holds the count at zero
//   load_val in  half-period length in clocks (>= 1)
//   count_en in  advance the count this cycle
//   terminal out count is at load_val-1 and advancing (wraps to 0 next)
module half_period_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count_en,
    output logic             terminal
);
    logic [WIDTH-1:0] count_q, count_d;
    assign terminal = run && count_en && (count_q == load_val - WIDTH'(1));
    assign count_d  = !run ? '0 : !count_en ? count_q : terminal ? '0 : count_q + WIDTH'(1);
    always_ff @(posedge clock or posedge reset)
        if (reset) count_q <= '0;
        else       count_q <= count_d;
endmodule

// File: rtl/clock_divider_sequencer.sv
// clock_divider_sequencer: stabilise after enable, then emit a programmable divided clock
//   clock     in  oscillator clock
//   reset     in  async active-high reset
//   enable    in  start (1) / stop (0) request
//   div_ratio in  new half-period ratio (0 treated as 1)
//   div_load  in  strobe capturing div_ratio as the pending ratio
//   clk_out   out registered divided clock, 50% duty
//   tick      out one-cycle pulse while clk_out has just risen
//   ready     out high while in RUN
//   state     out current FSM state
import clock_divider_pkg::*;
module clock_divider_sequencer #(
    parameter int STABLE_CYCLES = DEF_STABLE,
    parameter int DIV_WIDTH     = DIV_W,
    parameter int DEFAULT_DIV   = DEF_DIV
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div_ratio,
    input  logic                 div_load,
    output logic                 clk_out,
    output logic                 tick,
    output logic                 ready,
    output logic [1:0]           state
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    state_t               state_q, state_d;
    logic [SW-1:0]        stab_q, stab_d;
    logic                 clk_out_q, clk_out_d;
    logic                 tick_q, tick_d;
    logic [DIV_WIDTH-1:0] active_q, active_d, pending_q, pending_d;
    logic                 pending_valid_q, pending_valid_d;
    logic [DIV_WIDTH-1:0] new_div;
    logic                 counting, terminal, fall, rise;

    assign counting = (state_q == RUN) || (state_q == STOPPING);
    assign new_div  = sanitize_div(div_ratio);
    // A fall closes a full period, so it is the only safe point to swap ratios.
    assign fall     = terminal && clk_out_q;
    // Rising is suppressed while stopping or when RUN is being abandoned this cycle.
    assign rise     = terminal && !clk_out_q && (state_q == RUN) && enable;
    assign clk_out  = clk_out_q;
    assign tick     = tick_q;
    assign ready    = (state_q == RUN);
    assign state    = state_q;

    half_period_counter #(.WIDTH(DIV_WIDTH)) u_half_cnt (
        .clock    (clock),
        .reset    (reset),
        .run      (counting),
        .load_val (active_q),
        .count_en (counting),
        .terminal (terminal)
    );

    always_comb begin
        state_d         = state_q;
        stab_d          = stab_q;
        clk_out_d       = (clk_out_q && !fall) || rise;
        tick_d          = rise;
        active_d        = active_q;
        pending_d       = div_load ? new_div : pending_q;
        pending_valid_d = pending_valid_q || div_load;
        case (state_q)
            HOLD: begin
                stab_d = '0;
                if (enable) state_d = STABILIZE;
            end
            STABILIZE: begin
                if (!enable) begin
                    state_d = HOLD;
                    stab_d  = '0;
                end else if (stab_q == SW'(STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + SW'(1);
                end
            end
            RUN:      if (!enable) state_d = (clk_out_q && !terminal) ? STOPPING : HOLD;
            STOPPING: if (terminal) state_d = HOLD;
            default:  state_d = HOLD;
        endcase
        // A load coinciding with the boundary bypasses the pending register.
        if (fall) begin
            active_d        = div_load ? new_div : pending_valid_q ? pending_q : active_q;
            pending_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q         <= HOLD;
            stab_q          <= '0;
            clk_out_q       <= 1'b0;
            tick_q          <= 1'b0;
            active_q        <= DIV_WIDTH'(DEFAULT_DIV);
            pending_q       <= DIV_WIDTH'(DEFAULT_DIV);
            pending_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            stab_q          <= stab_d;
            clk_out_q       <= clk_out_d;
            tick_q          <= tick_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
        end
endmodule

// File: tb/tb_clock_divider_sequencer.sv
// tb_clock_divider_sequencer: directed checks of stabilisation, division, ratio change, stop and reset
module tb_clock_divider_sequencer;
    logic       clock = 1'b0;
    logic       reset, enable, div_load;
    logic [7:0] div_ratio;
    logic       clk_out, tick, ready;
    logic [1:0] state;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         stop_ticks = 0;
    int         n;

    clock_divider_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .div_ratio (div_ratio),
        .div_load  (div_load),
        .clk_out   (clk_out),
        .tick      (tick),
        .ready     (ready),
        .state     (state)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (state == 2'd3 && tick) stop_ticks++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit hit(input int sel);
        case (sel)
            0:       return ready === 1'b1;
            1:       return clk_out === 1'b1;
            2:       return clk_out === 1'b0;
            3:       return state === 2'd0;
            default: return state === 2'd1;
        endcase
    endfunction

    // Negedges until the condition holds; a timeout shows up as a wrong count.
    task automatic wait_for(input int sel, output int cnt);
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
        end while (!hit(sel) && cnt < 200);
    endtask

    task automatic load(input logic [7:0] r);
        div_ratio = r;
        div_load  = 1'b1;
        @(negedge clock);
        div_load  = 1'b0;
    endtask

    task automatic skip(input int k);
        repeat (k) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; div_load = 1'b0; div_ratio = 8'd0;
        skip(2);
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_ready", ready, 0);
        chk("rst_state", state, 0);
        reset = 1'b0; enable = 1'b1;
        wait_for(4, n); chk("hold_exit", n, 1);
        skip(7); enable = 1'b0;
        wait_for(3, n); chk("abort_to_hold", n, 1);
        chk("abort_ready", ready, 0);
        enable = 1'b1;
        wait_for(4, n); chk("restart_exit", n, 1);
        wait_for(0, n); chk("stab_window", n, 16);
        chk("run_state", state, 2);
        wait_for(1, n); chk("first_rise", n, 10);
        chk("first_tick", tick, 1);
        skip(1); chk("tick_one_cycle", tick, 0);
        wait_for(2, n); chk("high_10", n, 9);
        wait_for(1, n); chk("low_10", n, 10);
        skip(3); load(8'd3);
        wait_for(2, n); chk("old_high_completes", n, 6);
        wait_for(1, n); chk("new_low_3", n, 3);
        wait_for(2, n); chk("new_high_3", n, 3);
        wait_for(1, n); chk("new_low_3b", n, 3);
        chk("tick_div3", tick, 1);
        load(8'd0);
        wait_for(2, n); chk("high_before_div0", n, 2);
        wait_for(1, n); chk("div0_low", n, 1);
        chk("div0_tick_a", tick, 1);
        wait_for(2, n); chk("div0_high", n, 1);
        chk("div0_tick_off", tick, 0);
        wait_for(1, n); chk("div0_low_b", n, 1);
        chk("div0_tick_b", tick, 1);
        wait_for(2, n); chk("div0_high_b", n, 1);
        load(8'd4);
        load(8'd5);
        chk("bypass_fall", clk_out, 0);
        wait_for(1, n); chk("last_load_low", n, 5);
        wait_for(2, n); chk("last_load_high", n, 5);
        wait_for(1, n); chk("low_5", n, 5);
        skip(2); enable = 1'b0;
        skip(1);
        chk("stopping_state", state, 3);
        chk("stopping_ready", ready, 0);
        chk("stopping_clk", clk_out, 1);
        enable = 1'b1;
        wait_for(2, n); chk("stop_fall", n, 2);
        chk("stop_to_hold", state, 0);
        chk("stop_no_tick", stop_ticks, 0);
        wait_for(4, n); chk("rehold_exit", n, 1);
        wait_for(0, n); chk("rerun_window", n, 16);
        wait_for(1, n); chk("rerun_rise_5", n, 5);
        load(8'd7);
        reset = 1'b1;
        #1;
        chk("midrst_clk_out", clk_out, 0);
        chk("midrst_tick", tick, 0);
        chk("midrst_ready", ready, 0);
        chk("midrst_state", state, 0);
        @(negedge clock); reset = 1'b0;
        wait_for(4, n); chk("post_rst_exit", n, 1);
        wait_for(0, n); chk("post_rst_window", n, 16);
        wait_for(1, n); chk("post_rst_rise", n, 10);
        wait_for(2, n); chk("post_rst_high", n, 10);
        wait_for(1, n); chk("pending_dropped", n, 10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
